pe_out_drain: RTL and testbench
===============================

// Module: pe_out_drain
// PURPOSE
//   Drains the X_DIM x Y_DIM partial-sum matrix produced by the PE array into a single
//   valid/ready stream toward the output-feature buffer. On a capture pulse it snapshots
//   the whole pe_out matrix into a shadow register bank. It then emits one element per
//   handshake in row-major order, so the array can start the next pass immediately.
// PARAMETERS
//   X_DIM       5  rows of the PE array (outer drain index)
//   Y_DIM       5  columns of the PE array (inner drain index)
//   DATA_WIDTH  8  operand width; result elements are 2*DATA_WIDTH bits, two's complement
// PORTS
//   clk        in   1                      single clock, all logic on posedge
//   rst        in   1                      synchronous, active-low reset
//   capture    in   1                      1-cycle pulse: snapshot pe_in
//   pe_in      in   [X][Y][2*DATA_WIDTH]   registered pe_out matrix from the PE array
//   busy       out  1                      high from accepted capture until last element accepted
//   overrun    out  1                      1-cycle pulse: capture arrived while busy (dropped)
//   drain_done out  1                      1-cycle pulse, cycle after last element accepted
//   out_valid  out  1                      stream element valid
//   out_ready  in   1                      downstream accepts when valid && ready
//   out_data   out  2*DATA_WIDTH           element value
//   out_row    out  $clog2(X_DIM)          row index of out_data
//   out_col    out  $clog2(Y_DIM)          column index of out_data
// BEHAVIOUR
//   - Reset (rst==0 at posedge): state IDLE; busy, overrun, drain_done, out_valid,
//     out_data, out_row and out_col all 0. Shadow bank is not cleared.
//     Reset mid-drain abandons the drain; no drain_done.
//   - FSM has 2 states:
//     - IDLE --capture--> DRAIN. Shadow <= pe_in in the capture cycle; row=col=0.
//     - DRAIN: next cycle out_valid=1 presenting (0,0). Latency capture->valid is 1 cycle.
//     - DRAIN --handshake on (X_DIM-1,Y_DIM-1)--> IDLE. drain_done pulses next cycle.
//   - Handshake: element advances only on out_valid && out_ready.
//     out_data, out_row and out_col hold stable while valid && !ready.
//   - Drain order: col increments first; col wraps Y_DIM-1 -> 0 and row increments.
//     Exactly X_DIM*Y_DIM transfers per capture, no gaps if ready stays high.
//   - A capture in the same cycle as the final handshake is accepted (back-to-back):
//     shadow reloads, the FSM stays in DRAIN, busy stays 1, and (0,0) follows next cycle.
//     drain_done still pulses for the finished drain.
//   - Capture in DRAIN other than on the final handshake: ignored, shadow untouched,
//     overrun pulses 1 cycle later.
//   - out_ready while !out_valid: no effect.
// CONFIGURATION
//   PE_DRAIN_RELU_EN defined: out_data = (element < 0) ? 0 : element (signed compare),
//     applied combinationally on the shadow read, so latency is unchanged.
//   PE_DRAIN_RELU_EN undefined: out_data = raw shadow element, bit-exact.
// STRUCTURE
//   pe_pkg: ACC_WIDTH = 2*DATA_WIDTH constant; typedef enum logic {IDLE, DRAIN} drain_state_t.
//   Sub-module pe_drain_xy_cnt: row/col counter with wrap, clear, advance and last flag.
//   The FSM, shadow bank and output mux stay in pe_out_drain.
// TESTING
//   1. Basic drain: pe_in[i][j]=i*16+j, capture, ready=1 -> 25 beats 0x00,0x01..0x44
//      with matching row/col; drain_done at beat 25+1; busy low after.
//   2. Backpressure: ready toggles 1,0,0,1 pattern -> data, row and col held while
//      !ready; sequence identical to test 1; no beat lost or duplicated.
//   3. Overrun: capture again at beat 7 -> overrun pulses once; stream unchanged;
//      still exactly 25 beats.
//   4. Back-to-back: capture coincident with the final handshake using a new matrix
//      (all 0x1234) -> drain_done pulses, busy stays 1, then 25 beats of 0x1234 with no idle cycle.
//   5. Reset mid-drain: rst=0 at beat 10 -> next cycle all outputs 0, no drain_done;
//      a new capture then drains from (0,0).
//   6. PE_DRAIN_RELU_EN: pe_in[0][0]=16'hFF80 and pe_in[0][1]=16'h007F -> 0x0000 and
//      0x007F; without the macro -> 0xFF80 and 0x007F.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the PE output drain.
package pe_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

  typedef enum logic {IDLE, DRAIN} drain_state_t;
endpackage

// File: rtl/pe_drain_xy_cnt.sv
// Row-major (row, col) walker over an X_DIM x Y_DIM matrix; col is the fast index.
module pe_drain_xy_cnt #(
  parameter int X_DIM = 5,
  parameter int Y_DIM = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     adv,
  output logic [$clog2(X_DIM)-1:0] row,
  output logic [$clog2(Y_DIM)-1:0] col,
  output logic                     last
);
  localparam int RW = $clog2(X_DIM);
  localparam int CW = $clog2(Y_DIM);

  logic row_last, col_last;

  assign row_last = (row == RW'(X_DIM - 1));
  assign col_last = (col == CW'(Y_DIM - 1));
  assign last     = row_last && col_last;

  // Clear wins over advance so a fresh capture always restarts at (0,0).
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pe_out_drain.sv
// Snapshots the PE partial-sum matrix and streams it out row-major over valid/ready.
// Optional feature macro: PE_DRAIN_RELU_EN clamps negative elements to zero on output.
module pe_out_drain
  import pe_pkg::*;
#(
  parameter int X_DIM      = 5,
  parameter int Y_DIM      = 5,
  parameter int DATA_WIDTH = pe_pkg::DATA_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        capture,
  input  logic [X_DIM-1:0][Y_DIM-1:0][2*DATA_WIDTH-1:0] pe_in,
  output logic                                        busy,
  output logic                                        overrun,
  output logic                                        drain_done,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [2*DATA_WIDTH-1:0]                     out_data,
  output logic [$clog2(X_DIM)-1:0]                    out_row,
  output logic [$clog2(Y_DIM)-1:0]                    out_col
);
  localparam int ACC_W = 2 * DATA_WIDTH;

  drain_state_t state, state_nxt;
  logic [X_DIM-1:0][Y_DIM-1:0][ACC_W-1:0] shadow;
  logic [ACC_W-1:0] elem;
  logic load, fin, hs, last, overrun_nxt;

  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign hs        = out_valid && out_ready;

  pe_drain_xy_cnt #(.X_DIM(X_DIM), .Y_DIM(Y_DIM)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .adv (hs),
    .row (out_row),
    .col (out_col),
    .last(last)
  );

  // Next state; a capture on the final handshake reloads and keeps draining.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    fin         = 1'b0;
    overrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          load      = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && last) begin
          fin = 1'b1;
          if (capture) load = 1'b1;
          else         state_nxt = IDLE;
        end
        overrun_nxt = capture && !fin;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Shadow bank: deliberately not reset, only meaningful while draining.
  always_ff @(posedge clk) begin
    if (load) shadow <= pe_in;
  end

  // One-cycle status pulses, registered after the triggering edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drain_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      drain_done <= fin;
      overrun    <= overrun_nxt;
    end
  end

  assign elem = shadow[out_row][out_col];

  // Output mux; forced to zero when nothing is being presented.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
`ifdef PE_DRAIN_RELU_EN
      out_data = elem[ACC_W-1] ? '0 : elem;
`else
      out_data = elem;
`endif
    end
  end
endmodule

// File: tb/tb_pe_out_drain.sv
// Directed bench for pe_out_drain: basic drain, backpressure, overrun, back-to-back,
// reset mid-drain and the optional ReLU clamp (PE_DRAIN_RELU_EN).
module tb_pe_out_drain;
  import pe_pkg::*;

  logic clk = 1'b0;
  logic rst, capture, out_ready;
  logic [4:0][4:0][ACC_WIDTH-1:0] pe_in;
  logic busy, overrun, drain_done, out_valid;
  logic [ACC_WIDTH-1:0] out_data;
  logic [2:0] out_row, out_col;

  int total = 0;
  int bad   = 0;
  logic [ACC_WIDTH-1:0] exp_m [5][5];
  logic [4:0][4:0][ACC_WIDTH-1:0] mat;
  int nb, novr, ngap;

  always #5 clk = ~clk;

  pe_out_drain dut (
    .clk(clk), .rst(rst), .capture(capture), .pe_in(pe_in),
    .busy(busy), .overrun(overrun), .drain_done(drain_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ACC_WIDTH-1:0] model(input logic [ACC_WIDTH-1:0] v);
`ifdef PE_DRAIN_RELU_EN
    return v[ACC_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mat();
    pe_in = mat;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        exp_m[i][j] = mat[i][j];
  endtask

  // Sample-time loop over one drain. mode 1 = ready pattern 1,0,0,1.
  task automatic drain(input int mode, input int cap_beat, input bit b2b, input int rst_beat,
                       output int beats, output int ovr, output int gaps);
    int  k = 0;
    int  cyc = 0;
    bit  v, rdy, hit_rst;
    ovr = 0; gaps = 0; hit_rst = 0;
    while (k < 25 && cyc < 1000 && !hit_rst) begin
      v = out_valid;
      if (v) begin
        chk($sformatf("data[%0d]", k), out_data, model(exp_m[k/5][k%5]));
        chk($sformatf("row[%0d]", k), out_row, k / 5);
        chk($sformatf("col[%0d]", k), out_col, k % 5);
      end else gaps++;
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      out_ready = rdy;
      if (k == cap_beat) begin
        capture = 1'b1;
        cap_beat = -1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            pe_in[i][j] = 16'hBEEF;
      end
      if (b2b && k == 24 && v && rdy) begin
        capture = 1'b1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            pe_in[i][j] = 16'h1234;
      end
      if (k == rst_beat) begin
        rst = 1'b0;
        hit_rst = 1'b1;
      end
      tick();
      capture = 1'b0;
      if (overrun) ovr++;
      if (v && rdy && !hit_rst) k++;
      cyc++;
    end
    chk("drain_timeout", (cyc < 1000), 1);
    beats = k;
  endtask

  task automatic start();
    capture = 1'b1;
    tick();
    capture = 1'b0;
    chk("lat_valid", out_valid, 1);
    chk("lat_busy", busy, 1);
  endtask

  task automatic end_checks(input string t);
    chk({t, "_done"}, drain_done, 1);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_valid"}, out_valid, 0);
    tick();
    chk({t, "_done_pulse"}, drain_done, 0);
  endtask

  initial begin
    rst = 1'b0; capture = 1'b0; out_ready = 1'b0; pe_in = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    rst = 1'b1;

    // 1: basic drain, ready held high (also high while idle: no effect)
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        mat[i][j] = 16'(i * 16 + j);
    load_mat();
    out_ready = 1'b1;
    repeat (2) tick();
    chk("idle_valid", out_valid, 0);
    start();
    drain(0, -1, 0, -1, nb, novr, ngap);
    chk("t1_beats", nb, 25);
    chk("t1_gaps", ngap, 0);
    chk("t1_ovr", novr, 0);
    end_checks("t1");

    // 2: backpressure
    load_mat();
    start();
    drain(1, -1, 0, -1, nb, novr, ngap);
    chk("t2_beats", nb, 25);
    chk("t2_ovr", novr, 0);
    end_checks("t2");

    // 3: overrun at beat 7; pe_in changed to prove the shadow is untouched
    load_mat();
    start();
    drain(0, 7, 0, -1, nb, novr, ngap);
    chk("t3_beats", nb, 25);
    chk("t3_ovr", novr, 1);
    end_checks("t3");

    // 4: back-to-back capture on the final handshake
    load_mat();
    start();
    drain(0, -1, 1, -1, nb, novr, ngap);
    chk("t4a_beats", nb, 25);
    chk("t4a_ovr", novr, 0);
    chk("t4_done", drain_done, 1);
    chk("t4_busy", busy, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_data0", out_data, 16'h1234);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        exp_m[i][j] = 16'h1234;
    drain(0, -1, 0, -1, nb, novr, ngap);
    chk("t4b_beats", nb, 25);
    chk("t4b_gaps", ngap, 0);
    end_checks("t4b");

    // 5: reset mid-drain at beat 10
    load_mat();
    start();
    drain(0, -1, 0, 10, nb, novr, ngap);
    chk("t5_beats", nb, 10);
    chk("t5_busy", busy, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_row", out_row, 0);
    chk("t5_col", out_col, 0);
    chk("t5_done", drain_done, 0);
    chk("t5_ovr", overrun, 0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_no_done", drain_done, 0);
    end
    start();
    drain(0, -1, 0, -1, nb, novr, ngap);
    chk("t5b_beats", nb, 25);
    end_checks("t5b");

    // 6: signed elements, ReLU clamp when enabled
    mat[0][0] = 16'hFF80;
    mat[0][1] = 16'h007F;
    mat[2][2] = 16'h8000;
    load_mat();
    start();
`ifdef PE_DRAIN_RELU_EN
    chk("t6_e00", out_data, 16'h0000);
`else
    chk("t6_e00", out_data, 16'hFF80);
`endif
    drain(0, -1, 0, -1, nb, novr, ngap);
    chk("t6_beats", nb, 25);
    end_checks("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
